// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared channel state type, reset defaults and config legalisation
package clk_gen_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    localparam int DEF_DIV_C  = 256;
    localparam int DEF_HIGH_C = 128;

    // Returns {period, high_time}; callers slice each half down to their own field width.
    function automatic logic [63:0] legalise(input logic [31:0] d, input logic [31:0] h);
        logic [31:0] ld;
        logic [31:0] lh;
        ld = (d < 32'd2) ? 32'd2 : d;
        lh = (h == 32'd0) ? 32'd1 : h;
        if (lh >= ld) begin
            lh = ld - 32'd1;
        end
        return {ld, lh};
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: run/drain FSM, period counter, shadow/active config
module clk_div_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = DEF_DIV_C,
    parameter int DEF_HIGH = DEF_HIGH_C
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             pending
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    ch_state_e        state;
    ch_state_e        next_state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] act_high;
    logic [DIV_W-1:0] shd_div;
    logic [DIV_W-1:0] shd_high;
    logic             boundary;
    logic             apply;

    always_comb begin
        boundary   = (state != CH_IDLE) && (cnt == act_div - ONE);
        apply      = pending && ((state == CH_IDLE) || boundary);
        next_state = state;
        case (state)
            CH_IDLE: begin
                if (en) next_state = CH_RUN;
            end
            // Dropping en exactly on the last cycle ends the period now rather than draining a fresh one.
            CH_RUN: begin
                if (!en) next_state = boundary ? CH_IDLE : CH_DRAIN;
            end
            CH_DRAIN: begin
                if (en)            next_state = CH_RUN;
                else if (boundary) next_state = CH_IDLE;
            end
            default: next_state = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            act_div  <= DIV_W'(DEF_DIV);
            act_high <= DIV_W'(DEF_HIGH);
            shd_div  <= DIV_W'(DEF_DIV);
            shd_high <= DIV_W'(DEF_HIGH);
        end else begin
            state   <= next_state;
            cnt     <= ((state == CH_IDLE) || boundary) ? '0 : cnt + ONE;
            // Outputs trail the counter by one cycle, so a period start is always a clean 0->1 edge.
            clk_out <= (state != CH_IDLE) && (cnt < act_high);
            tick    <= (state != CH_IDLE) && (cnt == '0);
            pending <= wr_en || (pending && !apply);
            if (wr_en) begin
                shd_div  <= wr_div;
                shd_high <= wr_high;
            end
            if (apply) begin
                act_div  <= DIV_W'(legalise(32'(shd_div), 32'(shd_high)) >> 32);
                act_high <= DIV_W'(legalise(32'(shd_div), 32'(shd_high)));
            end
        end
    end

    assign running = (state != CH_IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - N_CH independent programmable clock dividers with shared config write port
module clk_div_multi
    import clk_gen_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = DEF_DIV_C,
    parameter int DEF_HIGH = DEF_HIGH_C,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  running,
    output logic [N_CH-1:0]  pending
);

    // Out-of-range channel numbers are dropped before decode so no channel sees them.
    logic wr_ok;
    assign wr_ok = wr_en && (int'(wr_ch) < N_CH);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_ch (
            .clk_in (clk_in),
            .reset  (reset),
            .en     (en[i]),
            .wr_en  (wr_ok && (wr_ch == CH_W'(i))),
            .wr_div (wr_div),
            .wr_high(wr_high),
            .clk_out(clk_out[i]),
            .tick   (tick[i]),
            .running(running[i]),
            .pending(pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized and directed bench for clk_div_multi against a period-level model
module tb_clk_div_multi;

    localparam int N  = 3;
    localparam int DW = 16;

    logic          clk_in  = 1'b0;
    logic          reset   = 1'b1;
    logic [N-1:0]  en      = '0;
    logic          wr_en   = 1'b0;
    logic [1:0]    wr_ch   = '0;
    logic [DW-1:0] wr_div  = '0;
    logic [DW-1:0] wr_high = '0;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;
    logic [N-1:0]  running;
    logic [N-1:0]  pending;

    clk_div_multi #(.N_CH(N), .DIV_W(DW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (en),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_high(wr_high),
        .clk_out(clk_out),
        .tick   (tick),
        .running(running),
        .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Model: per channel, whether a period is in progress, position within it, and configs.
    int m_run[N];
    int m_ph[N];
    int m_d[N];
    int m_h[N];
    int m_pend[N];
    int m_sd[N];
    int m_sh[N];
    logic [N-1:0] e_clk;
    logic [N-1:0] e_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void legal(input int d, input int h, output int ld, output int lh);
        ld = (d < 2) ? 2 : d;
        lh = (h == 0) ? 1 : h;
        if (lh >= ld) lh = ld - 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_ph[c] = 0; m_pend[c] = 0;
            m_d[c] = 256; m_h[c] = 128; m_sd[c] = 256; m_sh[c] = 128;
        end
        e_clk  = '0;
        e_tick = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            int at_end;
            int upd;
            int wrv;
            e_clk[c]  = (m_run[c] != 0) && (m_ph[c] < m_h[c]);
            e_tick[c] = (m_run[c] != 0) && (m_ph[c] == 0);
            at_end    = int'((m_run[c] != 0) && (m_ph[c] == m_d[c] - 1));
            upd       = int'((m_pend[c] != 0) && ((m_run[c] == 0) || (at_end != 0)));
            wrv       = int'(wr_en && (int'(wr_ch) == c));
            if ((m_run[c] == 0) || (at_end != 0)) begin
                m_ph[c]  = 0;
                m_run[c] = int'(en[c]);
            end else begin
                m_ph[c] = m_ph[c] + 1;
            end
            if (upd != 0) legal(m_sd[c], m_sh[c], m_d[c], m_h[c]);
            if (wrv != 0) begin
                m_sd[c] = int'(wr_div);
                m_sh[c] = int'(wr_high);
            end
            m_pend[c] = int'((wrv != 0) || ((m_pend[c] != 0) && (upd == 0)));
        end
    endtask

    task automatic step();
        logic [N-1:0] er;
        logic [N-1:0] ep;
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        for (int c = 0; c < N; c++) begin
            er[c] = (m_run[c] != 0);
            ep[c] = (m_pend[c] != 0);
        end
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("running", 32'(running), 32'(er));
        chk("pending", 32'(pending), 32'(ep));
    endtask

    task automatic wr(input int ch, input int d, input int h);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_div  = DW'(d);
        wr_high = DW'(h);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic measure(input int ch, output int per, output int hi);
        int n = 0;
        while (!tick[ch] && n < 1000) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(tick[ch]), 32'd1);
        hi  = int'(clk_out[ch]);
        per = 0;
        do begin
            step();
            per++;
            if (!tick[ch]) hi += int'(clk_out[ch]);
        end while (!tick[ch] && per < 1000);
    endtask

    initial begin
        int per;
        int hi;
        int n;
        model_reset();
        #12;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_pending", 32'(pending), 0);
        @(negedge clk_in);
        reset = 1'b0;

        en[0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tick[0] && n < 10);
        chk("start_latency", n, 2);
        measure(0, per, hi);
        chk("def_period", per, 256);
        chk("def_high", hi, 128);

        wr(1, 3, 1);
        step();
        en[1] = 1'b1;
        n = 0;
        while (!tick[1] && n < 10) begin step(); n++; end
        for (int i = 0; i < 9; i++) begin
            chk("d3_clk", 32'(clk_out[1]), 32'(i % 3 == 0));
            chk("d3_tick", 32'(tick[1]), 32'(i % 3 == 0));
            step();
        end

        wr(0, 10, 5);
        measure(0, per, hi);
        measure(0, per, hi);
        chk("d10_period", per, 10);
        chk("d10_high", hi, 5);
        step();
        step();
        wr(0, 4, 2);
        chk("rewrite_pending", 32'(pending[0]), 1);
        n = 0;
        while (!tick[0] && n < 20) begin step(); n++; end
        chk("old_period_tail", n, 7);
        measure(0, per, hi);
        chk("d4_period", per, 4);
        chk("d4_high", hi, 2);

        wr(2, 8, 4);
        step();
        en[2] = 1'b1;
        n = 0;
        while (!tick[2] && n < 10) begin step(); n++; end
        en[2] = 1'b0;
        hi = int'(clk_out[2]);
        n = 0;
        do begin step(); n++; hi += int'(clk_out[2]); end while (running[2] && n < 20);
        chk("drain_len", n, 7);
        chk("drain_high", hi, 4);

        wr(2, 0, 0);
        step();
        en[2] = 1'b1;
        measure(2, per, hi);
        chk("leg_d0_period", per, 2);
        chk("leg_h0_high", hi, 1);
        wr(2, 5, 9);
        measure(2, per, hi);
        measure(2, per, hi);
        chk("leg_h9_period", per, 5);
        chk("leg_h9_high", hi, 4);

        wr(3, 7, 3);
        chk("bad_ch_pending", 32'(pending), 0);
        measure(2, per, hi);
        chk("bad_ch_period", per, 5);
        chk("bad_ch_high", hi, 4);

        for (int i = 0; i < 1500; i++) begin
            int b;
            if ($urandom_range(15) == 0) begin
                b = int'($urandom_range(N - 1));
                en[b] = ~en[b];
            end
            if ($urandom_range(7) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = 2'($urandom_range(3));
                wr_div  = DW'($urandom_range(12));
                wr_high = DW'($urandom_range(14));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;

        en = '1;
        wr(0, 100, 60);
        measure(0, per, hi);
        measure(0, per, hi);
        chk("d100_period", per, 100);
        chk("d100_high", hi, 60);
        wr(1, 9, 4);
        for (int i = 0; i < 48; i++) step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_clk_out", 32'(clk_out), 0);
        chk("mid_rst_tick", 32'(tick), 0);
        chk("mid_rst_running", 32'(running), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        model_reset();
        en = '0;
        @(negedge clk_in);
        reset = 1'b0;
        en = 3'b011;
        n = 0;
        do begin step(); n++; end while (!tick[0] && n < 10);
        chk("post_rst_latency", n, 2);
        measure(1, per, hi);
        chk("post_rst_period", per, 256);
        chk("post_rst_high", hi, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
